// File: rtl/sfx_sequencer_if.sv
// Bus between the sound-effect sequencer, its game-event requesters,
// the note ROM and the tone generator.
interface sfx_sequencer_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned STEP_W  = 3
);
   localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned ADDR_W = ID_W + STEP_W;

   logic [NUM_REQ-1:0] req;
   logic [ADDR_W-1:0]  rom_addr;
   logic [14:0]        rom_data;
   logic [4:0]         note_idx;
   logic               tone_en;
   logic               busy;
   logic [ID_W-1:0]    active_id;
   logic               done;

   // Sequencer side
   modport master (
      input  req, rom_data,
      output rom_addr, note_idx, tone_en, busy, active_id, done
   );

   // Requesters, ROM and tone generator side
   modport slave (
      output req, rom_data,
      input  rom_addr, note_idx, tone_en, busy, active_id, done
   );
endinterface

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: latches effect requests, grants by fixed priority
// (id 0 highest, with preemption) and steps the granted effect's note list
// out of a sync ROM, holding each note for max(dur,1) ms ticks.
module sfx_sequencer #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned CLK_FREQ = 100000000,
   parameter int unsigned TICK_HZ  = 1000,
   parameter int unsigned STEP_W   = 3
) (
   input logic             clk,
   input logic             reset,
   sfx_sequencer_if.master bus
);
   localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned ADDR_W    = ID_W + STEP_W;
   localparam int unsigned TICK_CYC  = CLK_FREQ / TICK_HZ;
   localparam int unsigned PRE_W     = $clog2(TICK_CYC);
   localparam int unsigned NUM_STEPS = 2 ** STEP_W;

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_CYC - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;
   localparam logic [1:0] PLAY  = 2'd3;

   logic [1:0]         state,     stateNxt;
   logic [NUM_REQ-1:0] pending,   pendingNxt;
   logic [ADDR_W-1:0]  romAddr,   romAddrNxt;
   logic [4:0]         noteIdx,   noteIdxNxt;
   logic               toneEn,    toneEnNxt;
   logic               busy,      busyNxt;
   logic [ID_W-1:0]    activeId,  activeIdNxt;
   logic               done,      doneNxt;
   logic [STEP_W-1:0]  step,      stepNxt;
   logic [PRE_W-1:0]   prescaler, prescalerNxt;
   logic [7:0]         tickCnt,   tickCntNxt;
   logic               entryLast, entryLastNxt;

   logic               grantValid;
   logic [ID_W-1:0]    grantId;
   logic               startGrant;
   logic [NUM_REQ-1:0] grantMask;

   // Lowest-index pending request wins
   always_comb begin
      grantValid = 1'b0;
      grantId    = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (pending[i]) begin
            grantValid = 1'b1;
            grantId    = ID_W'(i);
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      stateNxt     = state;
      romAddrNxt   = romAddr;
      noteIdxNxt   = noteIdx;
      toneEnNxt    = toneEn;
      activeIdNxt  = activeId;
      doneNxt      = 1'b0;
      stepNxt      = step;
      prescalerNxt = prescaler;
      tickCntNxt   = tickCnt;
      entryLastNxt = entryLast;
      grantMask    = '0;

      // A new grant starts from IDLE or preempts a lower-priority effect
      startGrant = grantValid && ((state == IDLE) || (grantId < activeId));

      if (startGrant) begin
         grantMask   = NUM_REQ'(1) << grantId;
         activeIdNxt = grantId;
         stepNxt     = '0;
         romAddrNxt  = {grantId, STEP_W'(0)};
         stateNxt    = FETCH;
      end else begin
         case (state)
            FETCH: stateNxt = LOAD;
            LOAD: begin
               noteIdxNxt   = bus.rom_data[12:8];
               toneEnNxt    = ~bus.rom_data[13];
               entryLastNxt = bus.rom_data[14];
               prescalerNxt = '0;
               tickCntNxt   = (bus.rom_data[7:0] == 8'd0) ? 8'd1 : bus.rom_data[7:0];
               stateNxt     = PLAY;
            end
            PLAY: begin
               if (prescaler == PRE_LAST) begin
                  prescalerNxt = '0;
                  if (tickCnt == 8'd1) begin
                     if (entryLast || (step == STEP_LAST)) begin
                        toneEnNxt = 1'b0;
                        doneNxt   = 1'b1;
                        stateNxt  = IDLE;
                     end else begin
                        stepNxt    = step + STEP_W'(1);
                        romAddrNxt = {activeId, step + STEP_W'(1)};
                        stateNxt   = FETCH;
                     end
                  end else begin
                     tickCntNxt = tickCnt - 8'd1;
                  end
               end else begin
                  prescalerNxt = prescaler + PRE_W'(1);
               end
            end
            default: stateNxt = state;
         endcase
      end

      pendingNxt = (pending | bus.req) & ~grantMask;
      busyNxt    = (stateNxt != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pending   <= '0;
         romAddr   <= '0;
         noteIdx   <= '0;
         toneEn    <= 1'b0;
         busy      <= 1'b0;
         activeId  <= '0;
         done      <= 1'b0;
         step      <= '0;
         prescaler <= '0;
         tickCnt   <= '0;
         entryLast <= 1'b0;
      end else begin
         state     <= stateNxt;
         pending   <= pendingNxt;
         romAddr   <= romAddrNxt;
         noteIdx   <= noteIdxNxt;
         toneEn    <= toneEnNxt;
         busy      <= busyNxt;
         activeId  <= activeIdNxt;
         done      <= doneNxt;
         step      <= stepNxt;
         prescaler <= prescalerNxt;
         tickCnt   <= tickCntNxt;
         entryLast <= entryLastNxt;
      end
   end

   assign bus.rom_addr  = romAddr;
   assign bus.note_idx  = noteIdx;
   assign bus.tone_en   = toneEn;
   assign bus.busy      = busy;
   assign bus.active_id = activeId;
   assign bus.done      = done;
endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: a sync note ROM plus a reference model that turns
// each effect's ROM entries into the expected per-cycle output trace.
module tb_sfx_sequencer;
   localparam int unsigned NUM_REQ  = 4;
   localparam int unsigned STEP_W   = 3;
   localparam int unsigned TICK_CYC = 10;

   // Sample layout: {rom_addr[14:10], note_idx[9:5], tone_en[4], busy[3], done[2], active_id[1:0]}
   localparam logic [14:0] FULL    = 15'h7FFF;
   localparam logic [14:0] NO_NOTE = 15'b11111_00000_0_111_1;
   localparam logic [14:0] BD_ONLY = 15'h000C;

   typedef struct packed {
      logic [14:0] v;
      logic [14:0] m;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic [14:0] rom [0:31];
   exp_t expQ [$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sfx_sequencer_if #(.NUM_REQ(NUM_REQ), .STEP_W(STEP_W)) bus ();

   sfx_sequencer #(
      .NUM_REQ(NUM_REQ), .CLK_FREQ(1000), .TICK_HZ(100), .STEP_W(STEP_W)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // External synchronous note ROM
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   function automatic logic [14:0] mk(input int addr, input int note, input logic tone,
                                      input logic bsy, input logic dn, input int act);
      return {5'(addr), 5'(note), tone, bsy, dn, 2'(act)};
   endfunction

   function automatic logic [14:0] obs();
      return {bus.rom_addr, bus.note_idx, bus.tone_en, bus.busy, bus.done, bus.active_id};
   endfunction

   // Expected trace of one effect, starting at the first sample after its grant
   task automatic model_effect(input int id);
      logic [14:0] e;
      int len;
      expQ.push_back('{mk(id * 8, 0, 1'b0, 1'b1, 1'b0, id), NO_NOTE});
      expQ.push_back('{mk(id * 8, 0, 1'b0, 1'b1, 1'b0, id), NO_NOTE});
      for (int s = 0; s < 8; s++) begin
         e   = rom[id * 8 + s];
         len = ((e[7:0] == 8'd0) ? 1 : int'(e[7:0])) * int'(TICK_CYC);
         for (int c = 0; c < len; c++)
            expQ.push_back('{mk(id * 8 + s, int'(e[12:8]), ~e[13], 1'b1, 1'b0, id), FULL});
         if (e[14] || s == 7) begin
            expQ.push_back('{mk(id * 8 + s, int'(e[12:8]), 1'b0, 1'b0, 1'b1, id), FULL});
            break;
         end
         for (int g = 0; g < 2; g++)
            expQ.push_back('{mk(id * 8 + s + 1, int'(e[12:8]), ~e[13], 1'b1, 1'b0, id), FULL});
      end
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      bus.req = '0;
      repeat (3) @(negedge clk);
      total++;
      if (obs() !== 15'h0000) begin
         bad++;
         $display("FAIL reset outputs got=%h exp=0000", obs());
      end
      reset = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         total++;
         if (obs() !== 15'h0000) begin
            bad++;
            $display("FAIL idle_after_reset cyc=%0d got=%h exp=0000", k, obs());
         end
      end
   endtask

   task automatic test_single();
      exp_t e;
      rom[16] = 15'h0503;
      rom[17] = 15'h4902;
      bus.req = 4'b0100;
      @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      total++;
      if (bus.rom_addr !== 5'h10) begin
         bad++;
         $display("FAIL single_addr got=%h exp=10", bus.rom_addr);
      end
      model_effect(2);
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL single t=%0t got=%h exp=%h mask=%h", $time, obs(), e.v, e.m);
         end
         @(negedge clk);
      end
      total++;
      if (obs() !== mk(17, 9, 1'b0, 1'b0, 1'b0, 2)) begin
         bad++;
         $display("FAIL single_idle got=%h exp=%h", obs(), mk(17, 9, 1'b0, 1'b0, 1'b0, 2));
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      rom[8]  = 15'h4301;
      rom[24] = 15'h0401;
      rom[25] = 15'h4602;
      bus.req = 4'b1010;
      @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      model_effect(1);
      model_effect(3);
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL simultaneous t=%0t got=%h exp=%h mask=%h", $time, obs(), e.v, e.m);
         end
         @(negedge clk);
      end
      total++;
      if ((obs() & BD_ONLY) !== 15'h0000) begin
         bad++;
         $display("FAIL simultaneous_idle got=%h exp busy=0 done=0", obs());
      end
   endtask

   task automatic test_preempt();
      exp_t e;
      rom[24] = 15'h0B05;
      rom[25] = 15'h4C05;
      rom[0]  = 15'h0201;
      rom[1]  = 15'h6302;
      bus.req = 4'b1000;
      @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      model_effect(3);
      for (int k = 0; k < 20; k++) begin
         e = expQ.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL preempt_pre t=%0t got=%h exp=%h mask=%h", $time, obs(), e.v, e.m);
         end
         @(negedge clk);
      end
      expQ.delete();
      bus.req = 4'b0001;
      @(negedge clk);
      bus.req = '0;
      total++;
      if (bus.done !== 1'b0 || bus.active_id !== 2'd3) begin
         bad++;
         $display("FAIL preempt_hold done=%b id=%0d exp done=0 id=3", bus.done, bus.active_id);
      end
      @(negedge clk);
      model_effect(0);
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL preempt_new t=%0t got=%h exp=%h mask=%h", $time, obs(), e.v, e.m);
         end
         @(negedge clk);
      end
      for (int k = 0; k < 40; k++) begin
         total++;
         if (obs() !== mk(1, 3, 1'b0, 1'b0, 1'b0, 0)) begin
            bad++;
            $display("FAIL preempt_no_resume cyc=%0d got=%h exp=%h", k, obs(),
                     mk(1, 3, 1'b0, 1'b0, 1'b0, 0));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rest_eight();
      exp_t e;
      rom[8] = 15'h2704;
      rom[9] = 15'h0800;
      for (int s = 2; s < 8; s++)
         rom[8 + s] = {1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       8'($urandom_range(1, 2))};
      bus.req = 4'b0010;
      @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      model_effect(1);
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL rest_eight t=%0t got=%h exp=%h mask=%h", $time, obs(), e.v, e.m);
         end
         @(negedge clk);
      end
      total++;
      if ((obs() & BD_ONLY) !== 15'h0000) begin
         bad++;
         $display("FAIL rest_eight_idle got=%h exp busy=0 done=0", obs());
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int k;
      rom[16] = 15'h4A02;
      bus.req = 4'b0100;
      @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      model_effect(2);
      model_effect(2);
      k = 0;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if ((obs() & e.m) !== (e.v & e.m)) begin
            bad++;
            $display("FAIL back_to_back t=%0t got=%h exp=%h mask=%h", $time, obs(), e.v, e.m);
         end
         if (k == 10) bus.req = 4'b0100;
         if (k == 11) bus.req = '0;
         k++;
         @(negedge clk);
      end
      total++;
      if ((obs() & BD_ONLY) !== 15'h0000) begin
         bad++;
         $display("FAIL back_to_back_idle got=%h exp busy=0 done=0", obs());
      end
   endtask

   task automatic test_random();
      exp_t e;
      int id;
      for (int it = 0; it < 6; it++) begin
         id = int'($urandom_range(0, 3));
         for (int s = 0; s < 8; s++)
            rom[id * 8 + s] = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                               5'($urandom_range(0, 31)), 8'($urandom_range(0, 3))};
         bus.req = 4'(1 << id);
         @(negedge clk);
         bus.req = '0;
         @(negedge clk);
         model_effect(id);
         while (expQ.size() > 0) begin
            e = expQ.pop_front();
            total++;
            if ((obs() & e.m) !== (e.v & e.m)) begin
               bad++;
               $display("FAIL random it=%0d id=%0d t=%0t got=%h exp=%h mask=%h",
                        it, id, $time, obs(), e.v, e.m);
            end
            @(negedge clk);
         end
         total++;
         if ((obs() & BD_ONLY) !== 15'h0000) begin
            bad++;
            $display("FAIL random_idle it=%0d got=%h exp busy=0 done=0", it, obs());
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_in_play();
      rom[8] = 15'h0903;
      bus.req = 4'b0010;
      @(negedge clk);
      bus.req = '0;
      repeat (8) @(negedge clk);
      bus.req = 4'b1000;
      @(negedge clk);
      bus.req = '0;
      repeat (6) @(negedge clk);
      total++;
      if (bus.busy !== 1'b1 || bus.tone_en !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_play_pre busy=%b tone=%b exp 1 1", bus.busy, bus.tone_en);
      end
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (obs() !== 15'h0000) begin
         bad++;
         $display("FAIL reset_in_play got=%h exp=0000", obs());
      end
      reset = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         total++;
         if (obs() !== 15'h0000) begin
            bad++;
            $display("FAIL reset_in_play_idle cyc=%0d got=%h exp=0000", k, obs());
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rom[i] = 15'h4001;
      bus.req = '0;
      reset   = 1'b1;
      @(negedge clk);
      test_reset();
      test_single();
      test_simultaneous();
      test_preempt();
      test_rest_eight();
      test_back_to_back();
      test_random();
      test_reset_in_play();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
